// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants for the router input register stage and its neighbours
// (per-port FIFOs, synchroniser).
//   - ROUTER_DATA_W / ROUTER_ADDR_W : default beat and address-field widths
//   - ADDR_LSB / LEN_LSB            : header field positions for the default
//                                     layout (address in the low bits, length
//                                     field directly above it)
//   - ST_*                          : packet-framing FSM state encoding
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int ROUTER_DATA_W = 8;
    localparam int ROUTER_ADDR_W = 2;

    localparam int ADDR_LSB = 0;
    localparam int LEN_LSB  = ADDR_LSB + ROUTER_ADDR_W;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD_DATA = 3'd1;
    localparam logic [STATE_W-1:0] ST_HOLD      = 3'd2;
    localparam logic [STATE_W-1:0] ST_DROP      = 3'd3;
    localparam logic [STATE_W-1:0] ST_CHECK     = 3'd4;

endpackage

// File: rtl/router_parity_chk.sv
// ---------------------------------------------------------------------------
// router_parity_chk
// Running XOR parity of header + payload and comparison against the
// received parity beat.
// Ports:
//   clock, resetn  : clock, asynchronous active-low reset
//   soft_rst       : synchronous clear
//   hdr_load       : header accepted; restart calc_par from data_in and clear
//                    the previous packet's result
//   pay_acc        : payload beat; fold data_in into calc_par
//   par_load       : parity beat; capture data_in as rx_par
//   check          : compare calc_par against rx_par
//   data_in        : current input beat
//   parity_done    : compare has completed for the last packet
//   err            : parity mismatch on the last packet
// ---------------------------------------------------------------------------
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_rst,
    input  logic              hdr_load,
    input  logic              pay_acc,
    input  logic              par_load,
    input  logic              check,
    input  logic [DATA_W-1:0] data_in,
    output logic              parity_done,
    output logic              err
);

    logic [DATA_W-1:0] calc_par;
    logic [DATA_W-1:0] rx_par;

    // parity_done/err stay visible until the next header replaces them.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            calc_par    <= '0;
            rx_par      <= '0;
            parity_done <= 1'b0;
            err         <= 1'b0;
        end else if (soft_rst) begin
            calc_par    <= '0;
            rx_par      <= '0;
            parity_done <= 1'b0;
            err         <= 1'b0;
        end else if (hdr_load) begin
            calc_par    <= data_in;
            rx_par      <= '0;
            parity_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (pay_acc) begin
                calc_par <= calc_par ^ data_in;
            end
            if (par_load) begin
                rx_par <= data_in;
            end
            if (check) begin
                parity_done <= 1'b1;
                err         <= (calc_par != rx_par);
            end
        end
    end

endmodule

// File: rtl/router_reg_mp.sv
// ---------------------------------------------------------------------------
// router_reg_mp
// Router input register stage: frames the incoming byte stream (header,
// payload, parity), routes each beat to the destination FIFO selected by the
// header address, parks a beat in a holding register while that FIFO is
// full, drops packets addressed beyond NUM_PORTS, and checks parity.
//
// Optional build macro:
//   ROUTER_LEN_CHECK_EN : count payload beats (saturating, LEN_W bits) and
//                         flag len_err when the count differs from the header
//                         length field. Undefined: len_err is tied 0.
//
// Ports:
//   clock, resetn : clock, asynchronous active-low reset
//   soft_rst      : synchronous abort of the current packet
//   pkt_valid     : high on header/payload beats, low on the parity beat
//   data_in       : input beat
//   in_ready      : data_in is consumed this cycle
//   fifo_full     : per-port FIFO full flags (only the destination is used)
//   dout          : registered beat to the FIFOs (holds when not writing)
//   dout_valid    : one-hot write enable to the destination FIFO
//   busy          : FSM is not idle
//   parity_done   : parity compare completed for the last packet
//   err           : parity mismatch on the last packet
//   pkt_drop      : one-cycle pulse when an invalid-address packet ends
//   len_err       : length mismatch on the last packet (option only)
// ---------------------------------------------------------------------------
module router_reg_mp
    import router_pkg::*;
#(
    parameter int DATA_W    = ROUTER_DATA_W,
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = ROUTER_ADDR_W
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 soft_rst,
    input  logic                 pkt_valid,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 in_ready,
    input  logic [NUM_PORTS-1:0] fifo_full,
    output logic [DATA_W-1:0]    dout,
    output logic [NUM_PORTS-1:0] dout_valid,
    output logic                 busy,
    output logic                 parity_done,
    output logic                 err,
    output logic                 pkt_drop,
    output logic                 len_err
);

    logic [STATE_W-1:0]   state;
    logic [ADDR_W-1:0]    dest;
    logic [DATA_W-1:0]    hold_reg;
    logic                 hold_is_par;

    logic [ADDR_W-1:0]    hdr_addr;
    logic                 hdr_ok;
    logic [NUM_PORTS-1:0] hdr_onehot;
    logic [NUM_PORTS-1:0] dest_onehot;
    logic                 stall;

    logic                 hdr_accept;
    logic                 pay_acc;
    logic                 par_load;
    logic                 do_check;

    assign hdr_addr    = data_in[ADDR_LSB +: ADDR_W];
    assign hdr_ok      = (int'(hdr_addr) < NUM_PORTS);
    assign hdr_onehot  = NUM_PORTS'(1) << hdr_addr;
    assign dest_onehot = NUM_PORTS'(1) << dest;

    // Full flags of ports other than the destination are masked off.
    assign stall = |(fifo_full & dest_onehot);

    assign in_ready = (state == ST_IDLE) || (state == ST_LOAD_DATA) || (state == ST_DROP);
    assign busy     = (state != ST_IDLE);

    assign hdr_accept = (state == ST_IDLE) && pkt_valid;
    assign pay_acc    = (state == ST_LOAD_DATA) && pkt_valid;
    assign par_load   = (state == ST_LOAD_DATA) && !pkt_valid;
    assign do_check   = (state == ST_CHECK);

    // Framing FSM and output register. Every write lands one cycle after the
    // beat is consumed (or after the hold register is released), so dout and
    // dout_valid always come from flops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            dest        <= '0;
            hold_reg    <= '0;
            hold_is_par <= 1'b0;
            dout        <= '0;
            dout_valid  <= '0;
            pkt_drop    <= 1'b0;
        end else if (soft_rst) begin
            state       <= ST_IDLE;
            dest        <= '0;
            hold_reg    <= '0;
            hold_is_par <= 1'b0;
            dout        <= '0;
            dout_valid  <= '0;
            pkt_drop    <= 1'b0;
        end else begin
            dout_valid <= '0;
            pkt_drop   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        dest <= hdr_addr;
                        if (hdr_ok) begin
                            dout       <= data_in;
                            dout_valid <= hdr_onehot;
                            state      <= ST_LOAD_DATA;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_LOAD_DATA: begin
                    if (stall) begin
                        hold_reg    <= data_in;
                        hold_is_par <= !pkt_valid;
                        state       <= ST_HOLD;
                    end else begin
                        dout       <= data_in;
                        dout_valid <= dest_onehot;
                        if (!pkt_valid) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        dout       <= hold_reg;
                        dout_valid <= dest_onehot;
                        state      <= hold_is_par ? ST_CHECK : ST_LOAD_DATA;
                    end
                end
                ST_DROP: begin
                    if (!pkt_valid) begin
                        pkt_drop <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_parity_chk (
        .clock       (clock),
        .resetn      (resetn),
        .soft_rst    (soft_rst),
        .hdr_load    (hdr_accept),
        .pay_acc     (pay_acc),
        .par_load    (par_load),
        .check       (do_check),
        .data_in     (data_in),
        .parity_done (parity_done),
        .err         (err)
    );

`ifdef ROUTER_LEN_CHECK_EN
    localparam int LEN_W   = DATA_W - ADDR_W;
    localparam int LEN_POS = ADDR_LSB + ADDR_W;

    logic [LEN_W-1:0] pay_cnt;
    logic [LEN_W-1:0] len_field;
    logic             len_err_q;

    // The counter saturates so an over-long packet cannot wrap back onto a
    // matching count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pay_cnt   <= '0;
            len_field <= '0;
            len_err_q <= 1'b0;
        end else if (soft_rst) begin
            pay_cnt   <= '0;
            len_field <= '0;
            len_err_q <= 1'b0;
        end else if (hdr_accept) begin
            pay_cnt   <= '0;
            len_field <= data_in[LEN_POS +: LEN_W];
            len_err_q <= 1'b0;
        end else begin
            if (pay_acc && (pay_cnt != '1)) begin
                pay_cnt <= pay_cnt + 1'b1;
            end
            if (do_check) begin
                len_err_q <= (pay_cnt != len_field);
            end
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg_mp.sv
// ---------------------------------------------------------------------------
// tb_router_reg_mp
// Directed, table-driven bench for router_reg_mp (default parameters).
// Each vector is one clock cycle: inputs are driven, in_ready is compared
// before the edge, registered outputs are compared just after it.
// ---------------------------------------------------------------------------
module tb_router_reg_mp;

    localparam int DATA_W    = 8;
    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;

`ifdef ROUTER_LEN_CHECK_EN
    localparam logic LEN_EN = 1'b1;
`else
    localparam logic LEN_EN = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 resetn;
    logic                 soft_rst;
    logic                 pkt_valid;
    logic [DATA_W-1:0]    data_in;
    logic                 in_ready;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [DATA_W-1:0]    dout;
    logic [NUM_PORTS-1:0] dout_valid;
    logic                 busy;
    logic                 parity_done;
    logic                 err;
    logic                 pkt_drop;
    logic                 len_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    router_reg_mp #(
        .DATA_W    (DATA_W),
        .NUM_PORTS (NUM_PORTS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .soft_rst    (soft_rst),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .in_ready    (in_ready),
        .fifo_full   (fifo_full),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .parity_done (parity_done),
        .err         (err),
        .pkt_drop    (pkt_drop),
        .len_err     (len_err)
    );

    typedef struct {
        string                tag;
        logic                 sr;
        logic                 pv;
        logic [DATA_W-1:0]    din;
        logic [NUM_PORTS-1:0] ff;
        logic                 rdy;
        logic [NUM_PORTS-1:0] dv;
        logic [DATA_W-1:0]    dout;
        logic                 busy;
        logic                 pd;
        logic                 err;
        logic                 drop;
        logic                 lerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string tag, logic sr, logic pv, logic [7:0] din, logic [2:0] ff,
                                logic rdy, logic [2:0] dv, logic [7:0] dout_e, logic busy_e,
                                logic pd, logic err_e, logic drop, logic lerr);
        vec_t v;
        v.tag = tag; v.sr = sr; v.pv = pv; v.din = din; v.ff = ff;
        v.rdy = rdy; v.dv = dv; v.dout = dout_e; v.busy = busy_e;
        v.pd = pd; v.err = err_e; v.drop = drop; v.lerr = lerr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge: drive, compare in_ready, clock, compare.
    task automatic applyStimulus(input vec_t v);
        soft_rst  = v.sr;
        pkt_valid = v.pv;
        data_in   = v.din;
        fifo_full = v.ff;
        #1;
        checkOutput({v.tag, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
        @(posedge clock);
        #1;
        checkOutput({v.tag, ".dout_valid"},  32'(dout_valid),  32'(v.dv));
        checkOutput({v.tag, ".dout"},        32'(dout),        32'(v.dout));
        checkOutput({v.tag, ".busy"},        32'(busy),        32'(v.busy));
        checkOutput({v.tag, ".parity_done"}, 32'(parity_done), 32'(v.pd));
        checkOutput({v.tag, ".err"},         32'(err),         32'(v.err));
        checkOutput({v.tag, ".pkt_drop"},    32'(pkt_drop),    32'(v.drop));
        checkOutput({v.tag, ".len_err"},     32'(len_err),     32'(v.lerr & LEN_EN));
    endtask

    initial begin
        resetn    = 1'b0;
        soft_rst  = 1'b0;
        pkt_valid = 1'b0;
        data_in   = '0;
        fifo_full = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst.in_ready",    32'(in_ready),    32'd1);
        checkOutput("rst.dout",        32'(dout),        32'd0);
        checkOutput("rst.dout_valid",  32'(dout_valid),  32'd0);
        checkOutput("rst.busy",        32'(busy),        32'd0);
        checkOutput("rst.parity_done", 32'(parity_done), 32'd0);
        checkOutput("rst.err",         32'(err),         32'd0);
        checkOutput("rst.pkt_drop",    32'(pkt_drop),    32'd0);
        checkOutput("rst.len_err",     32'(len_err),     32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        //                 tag    sr pv din    ff      rdy dv      dout   bsy pd err drp lerr
        // Good packet to port 1
        vecs.push_back(mk("A0", 0, 1, 8'h0D, 3'b000, 1, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("A1", 0, 1, 8'h11, 3'b000, 1, 3'b010, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("A2", 0, 1, 8'h22, 3'b000, 1, 3'b010, 8'h22, 1, 0, 0, 0, 0));
        vecs.push_back(mk("A3", 0, 1, 8'h33, 3'b000, 1, 3'b010, 8'h33, 1, 0, 0, 0, 0));
        vecs.push_back(mk("A4", 0, 0, 8'h0D, 3'b000, 1, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("A5", 0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h0D, 0, 1, 0, 0, 0));
        vecs.push_back(mk("I0", 0, 0, 8'h55, 3'b000, 1, 3'b000, 8'h0D, 0, 1, 0, 0, 0));
        // Same packet, wrong parity
        vecs.push_back(mk("B0", 0, 1, 8'h0D, 3'b000, 1, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("B1", 0, 1, 8'h11, 3'b000, 1, 3'b010, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("B2", 0, 1, 8'h22, 3'b000, 1, 3'b010, 8'h22, 1, 0, 0, 0, 0));
        vecs.push_back(mk("B3", 0, 1, 8'h33, 3'b000, 1, 3'b010, 8'h33, 1, 0, 0, 0, 0));
        vecs.push_back(mk("B4", 0, 0, 8'h0C, 3'b000, 1, 3'b010, 8'h0C, 1, 0, 0, 0, 0));
        vecs.push_back(mk("B5", 0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h0C, 0, 1, 1, 0, 0));
        // Header clears err; stall on payload 0x22 and on the parity beat,
        // full flags of other ports ignored
        vecs.push_back(mk("C0", 0, 1, 8'h0D, 3'b101, 1, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C1", 0, 1, 8'h11, 3'b101, 1, 3'b010, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C2", 0, 1, 8'h22, 3'b010, 1, 3'b000, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C3", 0, 1, 8'h33, 3'b010, 0, 3'b000, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C4", 0, 1, 8'h33, 3'b010, 0, 3'b000, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C5", 0, 1, 8'h33, 3'b000, 0, 3'b010, 8'h22, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C6", 0, 1, 8'h33, 3'b000, 1, 3'b010, 8'h33, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C7", 0, 0, 8'h0D, 3'b010, 1, 3'b000, 8'h33, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C8", 0, 0, 8'h0D, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C9", 0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h0D, 0, 1, 0, 0, 0));
        // Invalid address 3: dropped
        vecs.push_back(mk("D0", 0, 1, 8'h07, 3'b000, 1, 3'b000, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("D1", 0, 1, 8'hAA, 3'b010, 1, 3'b000, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("D2", 0, 1, 8'hBB, 3'b000, 1, 3'b000, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("D3", 0, 0, 8'hCC, 3'b000, 1, 3'b000, 8'h0D, 0, 0, 0, 1, 0));
        vecs.push_back(mk("D4", 0, 0, 8'h00, 3'b000, 1, 3'b000, 8'h0D, 0, 0, 0, 0, 0));
        // Length 3 in header, only 2 payload beats, correct parity 0x3E
        vecs.push_back(mk("E0", 0, 1, 8'h0D, 3'b000, 1, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E1", 0, 1, 8'h11, 3'b000, 1, 3'b010, 8'h11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E2", 0, 1, 8'h22, 3'b000, 1, 3'b010, 8'h22, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E3", 0, 0, 8'h3E, 3'b000, 1, 3'b010, 8'h3E, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E4", 0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h3E, 0, 1, 0, 0, 1));
        // Port 0, length 1, one payload beat
        vecs.push_back(mk("G0", 0, 1, 8'h04, 3'b000, 1, 3'b001, 8'h04, 1, 0, 0, 0, 0));
        vecs.push_back(mk("G1", 0, 1, 8'h5A, 3'b000, 1, 3'b001, 8'h5A, 1, 0, 0, 0, 0));
        vecs.push_back(mk("G2", 0, 0, 8'h5E, 3'b000, 1, 3'b001, 8'h5E, 1, 0, 0, 0, 0));
        vecs.push_back(mk("G3", 0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h5E, 0, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // soft_rst while holding 0x22, then a clean packet to port 2
        applyStimulus(mk("S0",  0, 1, 8'h0D, 3'b000, 1, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        applyStimulus(mk("S1",  0, 1, 8'h11, 3'b000, 1, 3'b010, 8'h11, 1, 0, 0, 0, 0));
        applyStimulus(mk("S2",  0, 1, 8'h22, 3'b010, 1, 3'b000, 8'h11, 1, 0, 0, 0, 0));
        applyStimulus(mk("S3",  1, 1, 8'h33, 3'b010, 0, 3'b000, 8'h00, 0, 0, 0, 0, 0));
        applyStimulus(mk("S4",  0, 0, 8'h33, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0));
        applyStimulus(mk("S5",  0, 1, 8'h0E, 3'b000, 1, 3'b100, 8'h0E, 1, 0, 0, 0, 0));
        applyStimulus(mk("S6",  0, 1, 8'h01, 3'b000, 1, 3'b100, 8'h01, 1, 0, 0, 0, 0));
        applyStimulus(mk("S7",  0, 1, 8'h02, 3'b000, 1, 3'b100, 8'h02, 1, 0, 0, 0, 0));
        applyStimulus(mk("S8",  0, 1, 8'h03, 3'b000, 1, 3'b100, 8'h03, 1, 0, 0, 0, 0));
        applyStimulus(mk("S9",  0, 0, 8'h0E, 3'b000, 1, 3'b100, 8'h0E, 1, 0, 0, 0, 0));
        applyStimulus(mk("S10", 0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h0E, 0, 1, 0, 0, 0));

        // Zero-payload packet to port 2 (length 0)
        applyStimulus(mk("Z0", 0, 1, 8'h02, 3'b000, 1, 3'b100, 8'h02, 1, 0, 0, 0, 0));
        applyStimulus(mk("Z1", 0, 0, 8'h02, 3'b000, 1, 3'b100, 8'h02, 1, 0, 0, 0, 0));
        applyStimulus(mk("Z2", 0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h02, 0, 1, 0, 0, 0));

        // Asynchronous reset in the middle of a packet
        applyStimulus(mk("M0", 0, 1, 8'h0D, 3'b000, 1, 3'b010, 8'h0D, 1, 0, 0, 0, 0));
        pkt_valid = 1'b1;
        data_in   = 8'h11;
        resetn    = 1'b0;
        #1;
        checkOutput("M1.in_ready",   32'(in_ready),   32'd1);
        checkOutput("M1.dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("M1.dout",       32'(dout),       32'd0);
        checkOutput("M1.busy",       32'(busy),       32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        applyStimulus(mk("M2", 0, 0, 8'h11, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
